// File: rtl/sd_spi_card_responder_if.sv
// SPI-side and block-memory-side signal bundle for the SD SPI card responder.
// The slave modport is the card; the master modport is the host/memory side.
interface sd_spi_card_responder_if #(
   parameter int unsigned BLOCK_BYTES = 512
);
   localparam int unsigned AW = $clog2(BLOCK_BYTES);

   logic          sclk;
   logic          cs_n;
   logic          mosi;
   logic          miso;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_blk;
   logic [7:0]    mem_data;
   logic          cmd_valid;
   logic [5:0]    cmd_index;
   logic [31:0]   cmd_arg;
   logic          busy;

   modport slave (
      input  sclk, cs_n, mosi, mem_data,
      output miso, mem_addr, mem_blk, cmd_valid, cmd_index, cmd_arg, busy
   );

   modport master (
      output sclk, cs_n, mosi, mem_data,
      input  miso, mem_addr, mem_blk, cmd_valid, cmd_index, cmd_arg, busy
   );
endinterface

// File: rtl/sd_spi_card_responder.sv
// SD card SPI-mode responder: decodes command frames, answers R1, serves CMD17 block reads.
// Optional CRC7 check of incoming frames when CRC7_CHECK_EN is defined.
module sd_spi_card_responder #(
   parameter int unsigned NCR         = 1,
   parameter int unsigned NAC         = 2,
   parameter int unsigned BLOCK_BYTES = 512
) (
   input logic                    clk,
   input logic                    rst,
   sd_spi_card_responder_if.slave bus
);
   localparam int unsigned AW = $clog2(BLOCK_BYTES);
   localparam int unsigned CW = 13;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_CMD_RX   = 3'd1;
   localparam logic [2:0] S_NCR_WAIT = 3'd2;
   localparam logic [2:0] S_R1_TX    = 3'd3;
   localparam logic [2:0] S_NAC_WAIT = 3'd4;
   localparam logic [2:0] S_TOKEN_TX = 3'd5;
   localparam logic [2:0] S_DATA_TX  = 3'd6;
   localparam logic [2:0] S_CRC_TX   = 3'd7;

   logic [2:0]    state_q, state_d;
   logic          sclk_q;
   logic [47:0]   frame_q, frame_d;
   logic [5:0]    rx_cnt_q, rx_cnt_d;
   logic [7:0]    tx_q, tx_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [CW-1:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]    r1_q, r1_d;
   logic          data_ph_q, data_ph_d;
   logic          clr_idle_q, clr_idle_d;
   logic          idle_q, idle_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]   mem_blk_q, mem_blk_d;
   logic          cmd_valid_q, cmd_valid_d;
   logic [5:0]    cmd_index_q, cmd_index_d;
   logic [31:0]   cmd_arg_q, cmd_arg_d;

   logic rise, fall, frame_ok, crc_bad;

   assign rise     = !sclk_q &  bus.sclk;
   assign fall     =  sclk_q & !bus.sclk;
   assign frame_ok = frame_q[46] & frame_q[0];

`ifdef CRC7_CHECK_EN
   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int unsigned i = 0; i < 40; i++) begin
         fb = d[39-i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   assign crc_bad = (crc7(frame_q[47:8]) != frame_q[7:1]);
`else
   logic unused_frame_bits;
   assign unused_frame_bits = ^{frame_q[47], frame_q[7:1]};
   assign crc_bad = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      rx_cnt_d    = rx_cnt_q;
      tx_d        = tx_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      r1_d        = r1_q;
      data_ph_d   = data_ph_q;
      clr_idle_d  = clr_idle_q;
      idle_d      = idle_q;
      mem_addr_d  = mem_addr_q;
      mem_blk_d   = mem_blk_q;
      cmd_valid_d = 1'b0;
      cmd_index_d = cmd_index_q;
      cmd_arg_d   = cmd_arg_q;

      if (bus.cs_n) begin
         state_d   = S_IDLE;
         tx_d      = '1;
         rx_cnt_d  = '0;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (rise && !bus.mosi) begin
                  state_d  = S_CMD_RX;
                  rx_cnt_d = 6'd1;
                  frame_d  = {frame_q[46:0], 1'b0};
               end
            end

            S_CMD_RX: begin
               if (rx_cnt_q == 6'd48) begin
                  rx_cnt_d = '0;
                  if (frame_ok) begin
                     cmd_valid_d = 1'b1;
                     cmd_index_d = frame_q[45:40];
                     cmd_arg_d   = frame_q[39:8];
                     mem_blk_d   = frame_q[39:8];
                     state_d     = S_NCR_WAIT;
                     byte_cnt_d  = '0;
                     bit_cnt_d   = '0;
                     data_ph_d   = 1'b0;
                     clr_idle_d  = 1'b0;
                     if (crc_bad) begin
                        r1_d = {7'b0000100, idle_q};
                     end else begin
                        case (frame_q[45:40])
                           6'd0: begin
                              r1_d   = 8'h01;
                              idle_d = 1'b1;
                           end
                           6'd1: begin
                              r1_d       = {7'd0, idle_q};
                              clr_idle_d = 1'b1;
                           end
                           6'd17: begin
                              r1_d      = idle_q ? 8'h05 : 8'h00;
                              data_ph_d = !idle_q;
                           end
                           default: r1_d = {7'b0000010, idle_q};
                        endcase
                     end
                  end else begin
                     state_d = S_IDLE;
                  end
               end else if (rise) begin
                  frame_d  = {frame_q[46:0], bus.mosi};
                  rx_cnt_d = rx_cnt_q + 6'd1;
               end
            end

            default: begin
               // Transmit phases: a byte boundary (bit_cnt == 0) selects the next byte and phase.
               if (fall) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q != 3'd0) begin
                     tx_d = {tx_q[6:0], 1'b1};
                  end else begin
                     case (state_q)
                        S_NCR_WAIT: begin
                           if (byte_cnt_q == CW'(NCR)) begin
                              tx_d    = r1_q;
                              state_d = S_R1_TX;
                           end else begin
                              tx_d       = 8'hFF;
                              byte_cnt_d = byte_cnt_q + CW'(1);
                           end
                        end
                        S_R1_TX: begin
                           if (clr_idle_q) idle_d = 1'b0;
                           tx_d = 8'hFF;
                           if (data_ph_q) begin
                              state_d    = S_NAC_WAIT;
                              byte_cnt_d = CW'(1);
                           end else begin
                              state_d   = S_IDLE;
                              bit_cnt_d = '0;
                           end
                        end
                        S_NAC_WAIT: begin
                           if (byte_cnt_q == CW'(NAC)) begin
                              tx_d       = 8'hFE;
                              state_d    = S_TOKEN_TX;
                              mem_addr_d = '0;
                           end else begin
                              tx_d       = 8'hFF;
                              byte_cnt_d = byte_cnt_q + CW'(1);
                           end
                        end
                        S_TOKEN_TX: begin
                           tx_d       = bus.mem_data;
                           mem_addr_d = mem_addr_q + AW'(1);
                           byte_cnt_d = CW'(1);
                           state_d    = S_DATA_TX;
                        end
                        S_DATA_TX: begin
                           if (byte_cnt_q == CW'(BLOCK_BYTES)) begin
                              tx_d       = 8'h00;
                              state_d    = S_CRC_TX;
                              byte_cnt_d = CW'(1);
                           end else begin
                              tx_d       = bus.mem_data;
                              mem_addr_d = mem_addr_q + AW'(1);
                              byte_cnt_d = byte_cnt_q + CW'(1);
                           end
                        end
                        S_CRC_TX: begin
                           if (byte_cnt_q == CW'(2)) begin
                              tx_d      = 8'hFF;
                              state_d   = S_IDLE;
                              bit_cnt_d = '0;
                           end else begin
                              tx_d       = 8'h00;
                              byte_cnt_d = byte_cnt_q + CW'(1);
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sclk_q      <= 1'b1;
         frame_q     <= '1;
         rx_cnt_q    <= '0;
         tx_q        <= '1;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         r1_q        <= '1;
         data_ph_q   <= 1'b0;
         clr_idle_q  <= 1'b0;
         idle_q      <= 1'b1;
         mem_addr_q  <= '0;
         mem_blk_q   <= '0;
         cmd_valid_q <= 1'b0;
         cmd_index_q <= '0;
         cmd_arg_q   <= '0;
      end else begin
         state_q     <= state_d;
         sclk_q      <= bus.sclk;
         frame_q     <= frame_d;
         rx_cnt_q    <= rx_cnt_d;
         tx_q        <= tx_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         r1_q        <= r1_d;
         data_ph_q   <= data_ph_d;
         clr_idle_q  <= clr_idle_d;
         idle_q      <= idle_d;
         mem_addr_q  <= mem_addr_d;
         mem_blk_q   <= mem_blk_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_index_q <= cmd_index_d;
         cmd_arg_q   <= cmd_arg_d;
      end
   end

   assign bus.miso      = tx_q[7];
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_blk   = mem_blk_q;
   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd_index = cmd_index_q;
   assign bus.cmd_arg   = cmd_arg_q;
   assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Bench for sd_spi_card_responder: host-side SPI driver with an expected-byte scoreboard.
// Expectations for the CRC test follow CRC7_CHECK_EN.
module tb_sd_spi_card_responder;
   localparam int unsigned BB = 512;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sd_spi_card_responder_if #(.BLOCK_BYTES(BB)) bus ();

   sd_spi_card_responder #(.NCR(1), .NAC(2), .BLOCK_BYTES(BB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Block memory: byte i holds i[7:0], one clk of read latency.
   always @(posedge clk) bus.mem_data <= bus.mem_addr[7:0];

   int          vcount = 0;
   logic [5:0]  last_idx = '0;
   always @(negedge clk) begin
      if (bus.cmd_valid === 1'b1) begin
         vcount   = vcount + 1;
         last_idx = bus.cmd_index;
      end
   end

   int         errors = 0;
   int         checks = 0;
   logic [7:0] sb[$];
   logic [7:0] rx, exp;
   int         v0;

   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [47:0] mkf(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] head;
      head = {2'b01, idx, arg};
      return {head, crc7(head), 1'b1};
   endfunction

   task automatic sclk_bit(input logic b, output logic r);
      @(negedge clk);
      bus.sclk = 1'b0;
      bus.mosi = b;
      repeat (3) @(negedge clk);
      @(negedge clk);
      bus.sclk = 1'b1;
      r = bus.miso;
      repeat (3) @(negedge clk);
   endtask

   task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] r);
      for (int i = 7; i >= 0; i--) sclk_bit(tx[i], r[i]);
   endtask

   task automatic send_frame(input logic [47:0] f);
      logic [7:0] dummy;
      for (int b = 5; b >= 0; b--) xfer_byte(f[8*b +: 8], dummy);
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.cs_n = 1'b1; bus.sclk = 1'b1; bus.mosi = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.miso !== 1'b1) begin errors++; $display("FAIL reset_miso: got %b want 1", bus.miso); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %0h want 0", bus.mem_addr); end
      checks++; if (bus.mem_blk !== 32'h0) begin errors++; $display("FAIL reset_mem_blk: got %0h want 0", bus.mem_blk); end
      checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", bus.cmd_valid); end
      checks++; if (bus.cmd_index !== 6'd0) begin errors++; $display("FAIL reset_cmd_index: got %0d want 0", bus.cmd_index); end
      checks++; if (bus.cmd_arg !== 32'h0) begin errors++; $display("FAIL reset_cmd_arg: got %0h want 0", bus.cmd_arg); end
      bus.cs_n = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_cmd0();
      v0 = vcount;
      sb.push_back(8'hFF); sb.push_back(8'h01); sb.push_back(8'hFF);
      send_frame(48'h400000000095);
      while (sb.size() != 0) begin
         xfer_byte(8'hFF, rx); exp = sb.pop_front(); checks++;
         if (rx !== exp) begin errors++; $display("FAIL cmd0_resp: miso byte got %02h want %02h", rx, exp); end
      end
      checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL cmd0_valid_pulses: got %0d want %0d", vcount - v0, 1); end
      checks++; if (last_idx !== 6'd0) begin errors++; $display("FAIL cmd0_index: got %0d want 0", last_idx); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cmd0_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_cmd1();
      logic [7:0] r1_exp [2];
      r1_exp[0] = 8'h01;
      r1_exp[1] = 8'h00;
      for (int k = 0; k < 2; k++) begin
         sb.push_back(8'hFF); sb.push_back(r1_exp[k]); sb.push_back(8'hFF);
         send_frame(mkf(6'd1, 32'h0));
         while (sb.size() != 0) begin
            xfer_byte(8'hFF, rx); exp = sb.pop_front(); checks++;
            if (rx !== exp) begin errors++; $display("FAIL cmd1_resp%0d: miso byte got %02h want %02h", k, rx, exp); end
         end
      end
      checks++; if (last_idx !== 6'd1) begin errors++; $display("FAIL cmd1_index: got %0d want 1", last_idx); end
   endtask

   task automatic test_cmd17();
      sb.push_back(8'hFF); sb.push_back(8'h00); sb.push_back(8'hFF); sb.push_back(8'hFF);
      sb.push_back(8'hFE);
      for (int i = 0; i < BB; i++) sb.push_back(8'(i));
      sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'hFF);
      send_frame(mkf(6'd17, 32'h10));
      while (sb.size() != 0) begin
         xfer_byte(8'hFF, rx); exp = sb.pop_front(); checks++;
         if (rx !== exp) begin errors++; $display("FAIL cmd17_stream: miso byte got %02h want %02h (remaining %0d)", rx, exp, sb.size()); end
      end
      checks++; if (bus.mem_blk !== 32'h10) begin errors++; $display("FAIL cmd17_mem_blk: got %0h want 10", bus.mem_blk); end
      checks++; if (bus.cmd_arg !== 32'h10) begin errors++; $display("FAIL cmd17_cmd_arg: got %0h want 10", bus.cmd_arg); end
      checks++; if (last_idx !== 6'd17) begin errors++; $display("FAIL cmd17_index: got %0d want 17", last_idx); end
      checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL cmd17_mem_addr_wrap: got %0h want 0", bus.mem_addr); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cmd17_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_illegal();
      logic [47:0] frames [4];
      logic [7:0]  r1s [4];
      frames[0] = 48'h400000000095;        r1s[0] = 8'h01;
      frames[1] = mkf(6'd17, 32'h10);      r1s[1] = 8'h05;
      frames[2] = mkf(6'd5, 32'h0);        r1s[2] = 8'h05;
      frames[3] = 48'h400000000094;        r1s[3] = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         v0 = vcount;
         sb.push_back(8'hFF); sb.push_back(r1s[k]); sb.push_back(8'hFF); sb.push_back(8'hFF);
         send_frame(frames[k]);
         while (sb.size() != 0) begin
            xfer_byte(8'hFF, rx); exp = sb.pop_front(); checks++;
            if (rx !== exp) begin errors++; $display("FAIL illegal_resp%0d: miso byte got %02h want %02h", k, rx, exp); end
         end
         checks++;
         if (vcount - v0 !== ((k == 3) ? 0 : 1)) begin
            errors++; $display("FAIL illegal_valid%0d: pulses got %0d want %0d", k, vcount - v0, (k == 3) ? 0 : 1);
         end
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL illegal_busy%0d: got %b want 0", k, bus.busy); end
      end
   endtask

   task automatic test_abort();
      logic b;
      sb.push_back(8'hFF); sb.push_back(8'h01); sb.push_back(8'hFF);
      send_frame(mkf(6'd1, 32'h0));
      sb.push_back(8'hFF); sb.push_back(8'h00); sb.push_back(8'hFF); sb.push_back(8'hFF);
      sb.push_back(8'hFE);
      for (int i = 0; i < 100; i++) sb.push_back(8'(i));
      while (sb.size() > 105) begin
         xfer_byte(8'hFF, rx); exp = sb.pop_front(); checks++;
         if (rx !== exp) begin errors++; $display("FAIL abort_cmd1: miso byte got %02h want %02h", rx, exp); end
      end
      send_frame(mkf(6'd17, 32'h20));
      while (sb.size() != 0) begin
         xfer_byte(8'hFF, rx); exp = sb.pop_front(); checks++;
         if (rx !== exp) begin errors++; $display("FAIL abort_stream: miso byte got %02h want %02h", rx, exp); end
      end
      for (int i = 0; i < 4; i++) sclk_bit(1'b1, b);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", bus.busy); end
      @(negedge clk);
      bus.cs_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b want 0", bus.busy); end
      checks++; if (bus.miso !== 1'b1) begin errors++; $display("FAIL abort_miso_after: got %b want 1", bus.miso); end
      repeat (4) @(negedge clk);
      bus.cs_n = 1'b0;
      sb.push_back(8'hFF); sb.push_back(8'h01); sb.push_back(8'hFF);
      send_frame(48'h400000000095);
      while (sb.size() != 0) begin
         xfer_byte(8'hFF, rx); exp = sb.pop_front(); checks++;
         if (rx !== exp) begin errors++; $display("FAIL abort_cmd0: miso byte got %02h want %02h", rx, exp); end
      end
   endtask

   task automatic test_crc();
      logic [7:0] cmd1_r1;
`ifdef CRC7_CHECK_EN
      cmd1_r1 = 8'h09;
`else
      cmd1_r1 = 8'h01;
`endif
      v0 = vcount;
      sb.push_back(8'hFF); sb.push_back(cmd1_r1); sb.push_back(8'hFF);
      send_frame(48'h410000000095);
      while (sb.size() != 0) begin
         xfer_byte(8'hFF, rx); exp = sb.pop_front(); checks++;
         if (rx !== exp) begin errors++; $display("FAIL crc_cmd1: miso byte got %02h want %02h", rx, exp); end
      end
      checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL crc_cmd1_valid: pulses got %0d want 1", vcount - v0); end
      sb.push_back(8'hFF); sb.push_back(8'h01); sb.push_back(8'hFF);
      send_frame(48'h400000000095);
      while (sb.size() != 0) begin
         xfer_byte(8'hFF, rx); exp = sb.pop_front(); checks++;
         if (rx !== exp) begin errors++; $display("FAIL crc_cmd0: miso byte got %02h want %02h", rx, exp); end
      end
   endtask

   initial begin
      test_reset();
      test_cmd0();
      test_cmd1();
      test_cmd17();
      test_illegal();
      test_abort();
      test_crc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
